dram_pair_arbiter: RTL and testbench

Shares the single paired-address DRAM request path (k/l cache-line pair into the two-write request FIFO) among `NUM_REQ` requesters in the CLK_200M domain, such as the polling/read-load sequencer and several SMEM pipeline lanes. It grants requesters round-robin, gated by `stall` and an outstanding-pair credit limit, and writes each granted pair with its read tag. It routes each in-order k/l response pair back to the requester that issued it.

---
 rtl/dram_pair_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dram_pair_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_pair_arbiter.sv
// Round-robin arbiter sharing the paired k/l DRAM request path among NUM_REQ
// requesters, with credit-limited issue and in-order response routing.
module dram_pair_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 58,
    parameter int TAG_W   = 6,
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic                        CLK_200M,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        stall,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_k,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_l,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_wr_en,
    output logic [ADDR_W-1:0]           fifo_addr_1,
    output logic [ADDR_W-1:0]           fifo_addr_2,
    output logic [TAG_W-1:0]            fifo_tag,
    input  logic                        rsp_valid,
    input  logic [511:0]                rsp_data_k,
    input  logic [511:0]                rsp_data_l,
    output logic [NUM_REQ-1:0]          rsp_out_valid,
    output logic [511:0]                rsp_out_k,
    output logic [511:0]                rsp_out_l,
    output logic [TAG_W-1:0]            rsp_out_tag,
    output logic [CNT_W-1:0]            outstanding,
    output logic                        idle,
    output logic                        rsp_err
);

    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int ENT_W = RR_W + TAG_W;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    logic [RR_W-1:0]   r_rr;
    logic [CNT_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_rptr;
    logic [ENT_W-1:0]  r_own_mem [MAX_OUT];

    logic              w_can_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic              w_xfer;
    logic [RR_W-1:0]   w_gnt_idx;
    logic [RR_W-1:0]   w_rr_next;
    logic [ADDR_W-1:0] w_sel_k;
    logic [ADDR_W-1:0] w_sel_l;
    logic [TAG_W-1:0]  w_sel_tag;
    logic              w_own_empty;
    logic [ENT_W-1:0]  w_own_head;
    logic [RR_W-1:0]   w_head_owner;
    logic [TAG_W-1:0]  w_head_tag;
    logic              w_pop;

    // First valid requester at or after rr, wrapping around.
    function automatic logic [NUM_REQ-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                                     input logic [RR_W-1:0] rr);
        logic [NUM_REQ-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [RR_W-1:0] f_oh2idx(input logic [NUM_REQ-1:0] oh);
        logic [RR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | RR_W'(i);
        end
        return idx;
    endfunction

    // reset_n gating keeps req_ready at 0 while the block is held in reset.
    assign w_can_grant = reset_n & !stall & !clear & (outstanding < MAX_OUT_C);
    assign w_ready     = w_can_grant ? f_rr_pick(req_valid, r_rr) : '0;
    assign req_ready   = w_ready;
    assign w_xfer      = |(req_valid & w_ready);
    assign w_gnt_idx   = f_oh2idx(w_ready);
    assign w_rr_next   = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;

    assign w_sel_k   = req_addr_k[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_sel_l   = req_addr_l[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_sel_tag = req_tag[w_gnt_idx*TAG_W +: TAG_W];

    // Pointer difference doubles as the outstanding-pair count.
    assign outstanding  = r_wptr - r_rptr;
    assign w_own_empty  = (r_wptr == r_rptr);
    assign w_own_head   = r_own_mem[r_rptr[PTR_W-1:0]];
    assign w_head_owner = w_own_head[ENT_W-1:TAG_W];
    assign w_head_tag   = w_own_head[TAG_W-1:0];
    assign w_pop        = rsp_valid & !clear & !w_own_empty;
    assign idle         = (outstanding == '0) & !fifo_wr_en;

    always_ff @(posedge CLK_200M or negedge reset_n) begin
        if (!reset_n) begin
            r_rr          <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            fifo_wr_en    <= 1'b0;
            rsp_out_valid <= '0;
            rsp_err       <= 1'b0;
        end else if (clear) begin
            r_rr          <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            fifo_wr_en    <= 1'b0;
            rsp_out_valid <= '0;
            rsp_err       <= 1'b0;
        end else begin
            fifo_wr_en <= w_xfer;
            if (w_xfer) begin
                r_rr   <= w_rr_next;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end else if (rsp_valid) begin
                rsp_err <= 1'b1;
            end
            rsp_out_valid <= w_pop ? (NUM_REQ'(1) << w_head_owner) : '0;
        end
    end

    always_ff @(posedge CLK_200M or negedge reset_n) begin
        if (!reset_n) begin
            fifo_addr_1 <= '0;
            fifo_addr_2 <= '0;
            fifo_tag    <= '0;
            rsp_out_k   <= '0;
            rsp_out_l   <= '0;
            rsp_out_tag <= '0;
        end else begin
            if (w_xfer) begin
                fifo_addr_1 <= w_sel_k;
                fifo_addr_2 <= w_sel_l;
                fifo_tag    <= w_sel_tag;
            end
            if (w_pop) begin
                rsp_out_k   <= rsp_data_k;
                rsp_out_l   <= rsp_data_l;
                rsp_out_tag <= w_head_tag;
            end
        end
    end

    // Owner storage holds payload only; its occupancy lives in the pointers.
    always_ff @(posedge CLK_200M) begin
        if (w_xfer) begin
            r_own_mem[r_wptr[PTR_W-1:0]] <= {w_gnt_idx, w_sel_tag};
        end
    end

endmodule

// File: tb/tb_dram_pair_arbiter.sv
// Scoreboard bench for dram_pair_arbiter: a reference model predicts grants,
// FIFO writes and routed responses; a negedge monitor compares them.
module tb_dram_pair_arbiter;

    localparam int N  = 4;
    localparam int AW = 58;
    localparam int TW = 6;
    localparam int MO = 8;
    localparam int CW = 4;

    logic            CLK_200M = 1'b0;
    logic            reset_n  = 1'b0;
    logic            clear    = 1'b0;
    logic            stall    = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr_k = '0;
    logic [N*AW-1:0] req_addr_l = '0;
    logic [N*TW-1:0] req_tag = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [AW-1:0]   fifo_addr_1;
    logic [AW-1:0]   fifo_addr_2;
    logic [TW-1:0]   fifo_tag;
    logic            rsp_valid = 1'b0;
    logic [511:0]    rsp_data_k = '0;
    logic [511:0]    rsp_data_l = '0;
    logic [N-1:0]    rsp_out_valid;
    logic [511:0]    rsp_out_k;
    logic [511:0]    rsp_out_l;
    logic [TW-1:0]   rsp_out_tag;
    logic [CW-1:0]   outstanding;
    logic            idle;
    logic            rsp_err;

    dram_pair_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TAG_W(TW), .MAX_OUT(MO), .CNT_W(CW)) dut (
        .CLK_200M(CLK_200M), .reset_n(reset_n), .clear(clear), .stall(stall),
        .req_valid(req_valid), .req_addr_k(req_addr_k), .req_addr_l(req_addr_l),
        .req_tag(req_tag), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
        .fifo_addr_1(fifo_addr_1), .fifo_addr_2(fifo_addr_2), .fifo_tag(fifo_tag),
        .rsp_valid(rsp_valid), .rsp_data_k(rsp_data_k), .rsp_data_l(rsp_data_l),
        .rsp_out_valid(rsp_out_valid), .rsp_out_k(rsp_out_k), .rsp_out_l(rsp_out_l),
        .rsp_out_tag(rsp_out_tag), .outstanding(outstanding), .idle(idle), .rsp_err(rsp_err)
    );

    always #5 CLK_200M = ~CLK_200M;

    typedef struct { logic [AW-1:0] k; logic [AW-1:0] l; logic [TW-1:0] tag; } wr_t;
    typedef struct { logic [N-1:0] oh; logic [TW-1:0] tag; logic [511:0] k; logic [511:0] l; } rsp_t;
    typedef struct { int idx; logic [TW-1:0] tag; } own_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_rr   = 0;
    int   m_out  = 0;
    logic m_err  = 1'b0;
    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    own_t own_q[$];

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int i;
        r = '0;
        if (!reset_n || stall || clear || m_out >= MO) return r;
        for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (req_valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic m_clear();
        m_rr  = 0;
        m_out = 0;
        m_err = 1'b0;
        wr_q.delete();
        rsp_q.delete();
        own_q.delete();
    endtask

    // Reference model: evaluated on the pre-edge inputs at every clock edge.
    logic [N-1:0] m_g;
    int           m_i;
    own_t         m_o;
    always @(posedge CLK_200M or negedge reset_n) begin
        if (!reset_n) begin
            m_clear();
        end else if (clear) begin
            m_clear();
        end else begin
            m_g = exp_ready();
            if (rsp_valid) begin
                if (own_q.size() > 0) begin
                    m_o = own_q.pop_front();
                    rsp_q.push_back('{oh: N'(1) << m_o.idx, tag: m_o.tag, k: rsp_data_k, l: rsp_data_l});
                    m_out--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_g != '0) begin
                m_i = 0;
                for (int i = 0; i < N; i++) if (m_g[i]) m_i = i;
                wr_q.push_back('{k: req_addr_k[m_i*AW +: AW], l: req_addr_l[m_i*AW +: AW],
                                 tag: req_tag[m_i*TW +: TW]});
                own_q.push_back('{idx: m_i, tag: req_tag[m_i*TW +: TW]});
                m_rr = (m_i + 1) % N;
                m_out++;
            end
        end
    end

    wr_t  mon_w;
    rsp_t mon_r;
    always @(negedge CLK_200M) begin
        if (reset_n) begin
            chk("req_ready", req_ready, exp_ready());
            chk("outstanding", outstanding, m_out);
            chk("idle", idle, (m_out == 0) && (wr_q.size() == 0));
            chk("rsp_err", rsp_err, m_err);
            chk("fifo_wr_en", fifo_wr_en, wr_q.size() != 0);
            if (wr_q.size() != 0) begin
                mon_w = wr_q.pop_front();
                if (fifo_wr_en) begin
                    chk("fifo_addr_1", fifo_addr_1, mon_w.k);
                    chk("fifo_addr_2", fifo_addr_2, mon_w.l);
                    chk("fifo_tag", fifo_tag, mon_w.tag);
                end
            end
            chk("rsp_out_valid", rsp_out_valid, (rsp_q.size() != 0) ? rsp_q[0].oh : '0);
            if (rsp_q.size() != 0) begin
                mon_r = rsp_q.pop_front();
                if (rsp_out_valid != '0) begin
                    chk("rsp_out_tag", rsp_out_tag, mon_r.tag);
                    chk("rsp_out_k", rsp_out_k, mon_r.k);
                    chk("rsp_out_l", rsp_out_l, mon_r.l);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK_200M);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] k, input logic [AW-1:0] l,
                           input logic [TW-1:0] t);
        req_addr_k[i*AW +: AW] = k;
        req_addr_l[i*AW +: AW] = l;
        req_tag[i*TW +: TW]    = t;
    endtask

    task automatic drive_rsp();
        for (int j = 0; j < 16; j++) begin
            rsp_data_k[j*32 +: 32] = $urandom;
            rsp_data_l[j*32 +: 32] = $urandom;
        end
        rsp_valid = 1'b1;
    endtask

    task automatic drain();
        for (int b = 0; b < 20 && own_q.size() > 0; b++) begin
            drive_rsp();
            cyc();
        end
        rsp_valid = 1'b0;
        cyc();
        chk("drain_zero", outstanding, 0);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_fifo_wr_en"}, fifo_wr_en, 0);
        chk({pfx, "_fifo_addr_1"}, fifo_addr_1, 0);
        chk({pfx, "_fifo_addr_2"}, fifo_addr_2, 0);
        chk({pfx, "_fifo_tag"}, fifo_tag, 0);
        chk({pfx, "_rsp_out_valid"}, rsp_out_valid, 0);
        chk({pfx, "_rsp_out_k"}, rsp_out_k, 0);
        chk({pfx, "_rsp_out_l"}, rsp_out_l, 0);
        chk({pfx, "_rsp_out_tag"}, rsp_out_tag, 0);
        chk({pfx, "_outstanding"}, outstanding, 0);
        chk({pfx, "_idle"}, idle, 1);
        chk({pfx, "_rsp_err"}, rsp_err, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int g0;
    initial begin
        for (int i = 0; i < N; i++) set_req(i, AW'(58'h2000 + i * 16), AW'(58'h3000 + i * 16), TW'(i + 10));
        req_valid = '1;
        cyc(2);
        chk_reset_values("reset");
        req_valid = '0;
        reset_n   = 1'b1;
        cyc();

        // Single requester
        set_req(2, 58'h100, 58'h101, 6'd5);
        req_valid = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        cyc();
        req_valid = '0;
        chk("single_wr_en", fifo_wr_en, 1);
        chk("single_addr_1", fifo_addr_1, 58'h100);
        chk("single_addr_2", fifo_addr_2, 58'h101);
        chk("single_tag", fifo_tag, 5);
        chk("single_outstanding", outstanding, 1);
        cyc(2);
        drive_rsp();
        cyc();
        rsp_valid = 1'b0;
        chk("single_rsp_valid", rsp_out_valid, 4'b0100);
        chk("single_rsp_tag", rsp_out_tag, 5);
        chk("single_rsp_k", rsp_out_k, rsp_data_k);
        cyc();

        // Fairness from a zeroed pointer, running straight into the credit limit
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, AW'(58'h4000 + i), AW'(58'h5000 + i), TW'(i + 20));
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_grant", req_ready, 4'(1) << (k % 4));
            cyc();
        end
        req_valid = 4'b0001;
        #1 chk("credit_block", req_ready, 0);
        chk("credit_full", outstanding, 8);
        cyc(2);
        chk("credit_block_hold", req_ready, 0);
        drive_rsp();
        #1 chk("credit_same_cycle_block", req_ready, 0);
        cyc();
        rsp_valid = 1'b0;
        chk("credit_freed", outstanding, 7);
        #1 chk("credit_regrant", req_ready, 4'b0001);
        cyc();
        chk("credit_refull", outstanding, 8);
        drive_rsp();
        cyc();
        drive_rsp();
        #1 chk("credit_grant_and_rsp", req_ready, 4'b0001);
        cyc();
        chk("credit_unchanged", outstanding, 7);
        rsp_valid = 1'b0;
        req_valid = '0;
        drain();

        // Stall holds the pointer
        g0 = m_rr;
        req_valid = '1;
        #1 chk("stall_pre_grant", req_ready, 4'(1) << g0);
        cyc();
        stall = 1'b1;
        #1 chk("stall_block", req_ready, 0);
        chk("stall_reg_write", fifo_wr_en, 1);
        for (int s = 0; s < 4; s++) begin
            cyc();
            chk("stall_block", req_ready, 0);
            chk("stall_no_write", fifo_wr_en, 0);
        end
        cyc();
        stall = 1'b0;
        #1 chk("stall_resume", req_ready, 4'(1) << ((g0 + 1) % 4));
        cyc();
        req_valid = '0;
        drain();

        // Unowned response, then flush with pairs outstanding
        drive_rsp();
        cyc();
        rsp_valid = 1'b0;
        chk("err_set", rsp_err, 1);
        chk("err_no_delivery", rsp_out_valid, 0);
        req_valid = 4'b0010;
        cyc(3);
        req_valid = '0;
        chk("flush_pre", outstanding, 3);
        clear = 1'b1;
        drive_rsp();
        cyc();
        clear     = 1'b0;
        rsp_valid = 1'b0;
        chk("flush_outstanding", outstanding, 0);
        chk("flush_idle", idle, 1);
        chk("flush_err", rsp_err, 0);
        chk("flush_no_delivery", rsp_out_valid, 0);
        cyc();

        // Asynchronous reset in the middle of a burst
        req_valid = '1;
        cyc();
        drive_rsp();
        cyc();
        rsp_valid = 1'b0;
        cyc();
        #2 reset_n = 1'b0;
        #1 chk_reset_values("async");
        @(negedge CLK_200M);
        #2 reset_n = 1'b1;
        #1 chk("post_reset_first", req_ready, 4'b0001);
        cyc();
        req_valid = '0;
        cyc();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
